// File: rtl/bus_interconnect.sv
// Single-master, N-slave bus interconnect: top-byte prefix decode, one-hot slave
// select, registered request broadcast, timeout/unmapped error completion.
module bus_interconnect #(
    parameter int                         N_SLAVES     = 4,
    parameter logic [N_SLAVES-1:0][7:0]   SLAVE_PREFIX = {8'h30, 8'h20, 8'h10, 8'h00},
    parameter int                         TIMEOUT      = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    // master side
    input  logic                         m_valid,
    input  logic [31:0]                  m_address,
    input  logic [3:0]                   m_wstrobe,
    input  logic [31:0]                  m_wdata,
    output logic [31:0]                  m_rdata,
    output logic                         m_ready,
    output logic                         m_irq,
    // slave side
    output logic [N_SLAVES-1:0]          s_valid,
    output logic [31:0]                  s_address,
    output logic [3:0]                   s_wstrobe,
    output logic [31:0]                  s_wdata,
    input  logic [N_SLAVES-1:0][31:0]    s_rdata,
    input  logic [N_SLAVES-1:0]          s_ready,
    input  logic [N_SLAVES-1:0]          s_irq,
    // error reporting
    input  logic                         err_clear,
    output logic                         error,
    output logic [31:0]                  error_address
);

    // A zero TIMEOUT still needs a legal 1-bit counter; it is simply never compared.
    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ACTIVE, FAIL} state_t;

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [N_SLAVES-1:0]   sel_q, sel_d;      // one-hot selected slave
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  error_q, error_d;
    logic [31:0]           eaddr_q, eaddr_d;

    logic [N_SLAVES-1:0]   hit;
    logic [N_SLAVES-1:0]   pick;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;

    // Per-slave prefix comparators on the live master address.
    for (genvar g = 0; g < N_SLAVES; g++) begin : g_dec
        assign hit[g] = (m_address[31:24] == SLAVE_PREFIX[g]);
    end

    // Priority pick: scan downward so the lowest hitting index is the one left.
    always_comb begin
        pick = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    // Mux ready/rdata of the latched selection; non-selected slaves are masked off.
    always_comb begin
        sel_ready = |(s_ready & sel_q);
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | s_rdata[i];
        end
    end

    // Next-state and output logic of the transaction FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        error_d = error_q & ~err_clear;
        eaddr_d = eaddr_q;
        s_valid = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        unique case (state_q)
            IDLE: begin
                if (m_valid) begin
                    addr_d  = m_address;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrobe;
                    sel_d   = pick;
                    cnt_d   = '0;
                    state_d = (|hit) ? ACTIVE : FAIL;
                end
            end
            ACTIVE: begin
                s_valid = sel_q;
                m_ready = sel_ready;
                if (sel_ready) begin
                    m_rdata = sel_rdata;
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d = FAIL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FAIL: begin
                // Set overrides a simultaneous err_clear.
                m_ready = 1'b1;
                error_d = 1'b1;
                eaddr_d = addr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            eaddr_q <= eaddr_d;
        end
    end

    assign s_address     = addr_q;
    assign s_wdata       = wdata_q;
    assign s_wstrobe     = wstrb_q;
    assign error         = error_q;
    assign error_address = eaddr_q;
    assign m_irq         = |s_irq;

endmodule

// File: tb/tb_bus_interconnect.sv
// Randomized scoreboard bench for bus_interconnect with a transaction-level model.
module tb_bus_interconnect;

    localparam int               NS  = 4;
    localparam int               TMO = 15;
    // Slices 1 and 3 overlap on 0x20 so the lowest-index rule is exercised.
    localparam logic [NS-1:0][7:0] PFX = {8'h20, 8'h30, 8'h20, 8'h00};

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  m_valid;
    logic [31:0]           m_address;
    logic [3:0]            m_wstrobe;
    logic [31:0]           m_wdata;
    logic [31:0]           m_rdata;
    logic                  m_ready;
    logic                  m_irq;
    logic [NS-1:0]         s_valid;
    logic [31:0]           s_address;
    logic [3:0]            s_wstrobe;
    logic [31:0]           s_wdata;
    logic [NS-1:0][31:0]   s_rdata;
    logic [NS-1:0]         s_ready;
    logic [NS-1:0]         s_irq;
    logic                  err_clear;
    logic                  error;
    logic [31:0]           error_address;

    bus_interconnect #(.N_SLAVES(NS), .SLAVE_PREFIX(PFX), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_address(m_address), .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_irq(m_irq),
        .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .s_irq(s_irq),
        .err_clear(err_clear), .error(error), .error_address(error_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [NS-1:0] sel_oh;
        logic        fail;
        int          act;     // cycles s_valid is expected high
        logic [31:0] rdata;
    } exp_t;

    exp_t    q[$];
    int      vec = 0;
    int      err = 0;
    int      cur_wait = 0;
    int      scnt;
    logic [NS-1:0] noise;
    logic    clr_en = 1'b0;

    function automatic logic [31:0] slave_data(input int i, input logic [31:0] a);
        return a ^ (32'h1111_1111 * 32'(i + 1));
    endfunction

    // Slave models: data is a function of index and address; unselected slaves toggle ready randomly.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_rdata[i] = slave_data(i, s_address);
            s_ready[i] = s_valid[i] ? (scnt == cur_wait) : noise[i];
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)          scnt <= 0;
        else if (|s_valid)   scnt <= scnt + 1;
        else                 scnt <= 0;
    end

    // Background random irq, ready noise and err_clear pulses.
    initial begin
        noise = '0; s_irq = '0; err_clear = 1'b0;
        forever begin
            @(posedge clk); #1;
            noise     = NS'($urandom);
            s_irq     = NS'($urandom);
            err_clear = clr_en && ($urandom_range(0, 5) == 0);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vec++;
        if (act !== expv) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: first matching prefix, then timeout if the slave waits TIMEOUT cycles or more.
    function automatic exp_t model(input logic [31:0] a, input logic [3:0] ws,
                                   input logic [31:0] wd, input int w);
        exp_t e;
        int   sel = -1;
        for (int i = 0; i < NS; i++)
            if (sel < 0 && a[31:24] == PFX[i]) sel = i;
        e.addr = a; e.wdata = wd; e.wstrb = ws; e.sel_oh = '0;
        if (sel < 0) begin
            e.fail = 1'b1; e.act = 0; e.rdata = '0;
        end else begin
            e.sel_oh[sel] = 1'b1;
            if (w >= TMO) begin
                e.fail = 1'b1; e.act = TMO; e.rdata = '0;
            end else begin
                e.fail = 1'b0; e.act = w + 1; e.rdata = slave_data(sel, a);
            end
        end
        return e;
    endfunction

    task automatic do_req(input logic [31:0] a, input logic [3:0] ws,
                          input logic [31:0] wd, input int w);
        int n = 0;
        q.push_back(model(a, ws, wd, w));
        cur_wait  = w;
        m_valid   = 1'b1;
        m_address = a;
        m_wstrobe = ws;
        m_wdata   = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ready && n < 60);
        if (!m_ready) chk("req_no_ready", 64'(m_ready), 64'd1);
        @(posedge clk); #1;
        m_valid = 1'b0;
    endtask

    // Monitor: error/irq/rdata invariants every cycle, scoreboard pop on m_ready.
    int       act_cnt = 0;
    logic     exp_err = 1'b0;
    logic [31:0] exp_eaddr = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                q.delete();
                exp_err = 1'b0; exp_eaddr = '0; act_cnt = 0;
            end else begin
                chk("m_irq", 64'(m_irq), 64'(|s_irq));
                chk("error_flag", {31'd0, error, error_address}, {31'd0, exp_err, exp_eaddr});
                if (!m_ready) chk("rdata_idle_zero", 64'(m_rdata), 64'd0);
                if (s_valid != '0) begin
                    if (q.size() == 0) chk("s_valid_unexpected", 64'(s_valid), 64'd0);
                    else begin
                        chk("s_valid_sel", 64'(s_valid), 64'(q[0].sel_oh));
                        chk("s_bcast", {s_address, s_wdata}, {q[0].addr, q[0].wdata});
                        chk("s_wstrobe", 64'(s_wstrobe), 64'(q[0].wstrb));
                    end
                    act_cnt++;
                end
                if (m_ready) begin
                    if (q.size() == 0) chk("m_ready_unexpected", 64'(m_ready), 64'd0);
                    else begin
                        e = q.pop_front();
                        chk("m_rdata", 64'(m_rdata), 64'(e.rdata));
                        chk("wait_cycles", 64'(act_cnt), 64'(e.act));
                        if (e.fail) chk("fail_s_valid", 64'(s_valid), 64'd0);
                    end
                    act_cnt = 0;
                end
                if (err_clear) exp_err = 1'b0;
                if (m_ready && e.fail) begin
                    exp_err   = 1'b1;
                    exp_eaddr = e.addr;
                end
                if (m_ready) e.fail = 1'b0;
            end
        end
    end

    // Stimulus: reset state, directed plan items, random traffic, reset mid-flight.
    initial begin
        logic [7:0] tops [6];
        int n;
        tops = '{8'h00, 8'h20, 8'h30, 8'h10, 8'h7F, 8'h00};
        reset = 1'b0; m_valid = 1'b0; m_address = '0; m_wstrobe = '0; m_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_m_ready", 64'(m_ready), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata), 64'd0);
        chk("rst_error", {31'd0, error, error_address}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        clr_en = 1'b1;

        do_req(32'h0000_0100, 4'h0, 32'h0,  0);     // RAM zero-wait read
        do_req(32'h2000_0000, 4'hF, 32'h41, 3);     // three wait states on slave 1
        do_req(32'h7F00_0000, 4'h0, 32'h0,  0);     // unmapped
        do_req(32'h1000_0000, 4'h0, 32'h0,  1);     // unmapped in this map
        do_req(32'h3000_0010, 4'h0, 32'h0,  TMO-1); // ready in the last allowed cycle
        do_req(32'h3000_0020, 4'h3, 32'h55, TMO);   // one cycle too late
        do_req(32'h3000_0030, 4'h0, 32'h0,  1000);  // never ready
        do_req(32'h2000_0004, 4'h0, 32'h0,  2);     // overlap -> slave 1

        for (int k = 0; k < 250; k++) begin
            logic [31:0] a;
            int w, gap;
            a = $urandom;
            a[31:24] = (k % 6 == 5) ? 8'($urandom) : tops[$urandom_range(0, 4)];
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 3, TMO + 5) : $urandom_range(0, 4);
            do_req(a, 4'($urandom), $urandom, w);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

        // Reset during ACTIVE with the sticky error already set.
        clr_en = 1'b0;
        @(posedge clk); #1;
        do_req(32'h7F00_0000, 4'h0, 32'h0, 0);
        q.push_back(model(32'h3000_0000, 4'h0, 32'h0, 1000));
        cur_wait = 1000; m_valid = 1'b1; m_address = 32'h3000_0000;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_s_valid", 64'(s_valid), 64'b0100);
        chk("pre_rst_error", 64'(error), 64'd1);
        reset = 1'b0; m_valid = 1'b0;
        #1;
        chk("midrst_s_valid", 64'(s_valid), 64'd0);
        chk("midrst_m_ready", 64'(m_ready), 64'd0);
        chk("midrst_error", 64'(error), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        do_req(32'h0000_0000, 4'h0, 32'h0, 0);

        n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (q.size() != 0) chk("scoreboard_drain", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/bus_interconnect.md
# bus_interconnect

Parametrised single-master, N-slave bus interconnect for the Virgule CPU bus, replacing per-bench hand-written address decode. It decodes the top address byte against a configurable prefix table and routes requests to the selected slave. It returns rdata/ready to the CPU and ORs slave interrupts. It also completes unmapped or hung transactions with an error response instead of stalling the CPU. It sits between the CPU master port and RAM, text-output and peripheral slaves.

## Interface

**Parameters**

- N_SLAVES, 4, number of slave ports (1..16).
- SLAVE_PREFIX, {8'h30, 8'h20, 8'h10, 8'h00}, packed N_SLAVES×8 bits; slice i holds the address[31:24] prefix of slave i.
- TIMEOUT, 15, maximum number of slave wait cycles before forced completion; 0 disables the timeout.

**Ports**

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_valid  in  1  master request valid; held with address/wdata/wstrobe until m_ready.
- m_address  in  32  master address.
- m_wstrobe  in  4  byte write enables; 0 means read.
- m_wdata  in  32  write data.
- m_rdata  out  32  read data; 0 whenever m_ready=0.
- m_ready  out  1  transaction complete, single-cycle pulse.
- m_irq  out  1  OR of s_irq.
- s_valid  out  N_SLAVES  one-hot per-slave request.
- s_address  out  32  broadcast of the latched address.
- s_wstrobe  out  4  broadcast of the latched wstrobe.
- s_wdata  out  32  broadcast of the latched wdata.
- s_rdata  in  N_SLAVES×32  slave read data; slice i belongs to slave i.
- s_ready  in  N_SLAVES  slave ready.
- s_irq  in  N_SLAVES  slave interrupts.
- err_clear  in  1  clears the sticky error.
- error  out  1  sticky flag; set on an unmapped or timed-out access.
- error_address  out  32  address of the most recent failed access.

## Operation

**FSM states:** IDLE, ACTIVE, FAIL.

**IDLE**
- On m_valid, latch address, wstrobe, wdata and the decode result.
- Decode: slave i hits when address[31:24] == SLAVE_PREFIX[i].
- If several slaves hit, the lowest index wins.
- Hit: go to ACTIVE with the selected index latched and the wait counter at 0.
- Miss: go to FAIL.

**ACTIVE**
- s_valid[sel]=1; all other s_valid bits are 0.
- m_ready = s_ready[sel] and m_rdata = s_rdata[sel] (combinational pass-through).
- When s_ready[sel]=1: go to IDLE.
- Otherwise, with TIMEOUT≠0 and counter == TIMEOUT−1: go to FAIL.
- Otherwise: increment the counter. The counter width is $clog2(TIMEOUT+1).

**FAIL** (lasts one cycle)
- s_valid=0, m_ready=1, m_rdata=0.
- error←1 and error_address←latched address.
- Go to IDLE.

**Error and interrupts**
- err_clear clears error; error_address is kept.
- If a set event and err_clear occur in the same cycle, the set wins.
- m_irq is purely combinational and independent of the FSM.

**Reset (asynchronous, any time)**
- FSM goes to IDLE, counter=0, s_valid=0, m_ready=0, m_rdata=0.
- error=0, error_address=0, latched registers=0.
- An in-flight transaction is abandoned with no response.

## Timing

- Request latency: m_valid seen at edge 0 → s_valid high from cycle 1. The interconnect adds one cycle over a direct connection.
- Zero-wait slave: s_ready in cycle 1 → m_ready in cycle 1.
- Unmapped access: m_ready in cycle 1 through FAIL; error visible from cycle 2.
- Timeout: the slave is given cycles 1..TIMEOUT.
  - s_ready in cycle TIMEOUT completes normally.
  - No s_ready by then: FAIL in cycle TIMEOUT+1, and s_valid drops that cycle.
- Back-to-back: after an m_ready cycle the FSM is in IDLE. If m_valid is still high it is taken as a new request, with s_valid in the following cycle.
- The s_* broadcast signals come from the latches, so they stay stable for the whole ACTIVE phase regardless of the master.
- A slave's s_ready while it is not selected is ignored.

## Test plan

- **RAM read:** read at 0x0000_0100, slave 0 returns 0xDEADBEEF with ready in its first cycle.
  → s_valid=4'b0001 at cycle 1, m_ready=1 and m_rdata=0xDEADBEEF at cycle 1, error=0.
- **Wait states:** write 0x1000_0000 with wstrobe=4'hF and wdata=0x41, slave 1 ready after 3 wait cycles.
  → s_valid=4'b0010 for cycles 1..4, m_ready only at cycle 4, s_wdata=0x41 throughout.
- **Unmapped:** read at 0x7F00_0000.
  → no s_valid, m_ready=1 and m_rdata=0 at cycle 1, error=1 and error_address=0x7F00_0000 at cycle 2.
  → err_clear then gives error=0.
- **Timeout boundary:** TIMEOUT=15 on slave 2.
  → ready in cycle 15 completes normally with error=0.
  → slave never ready: s_valid drops and m_ready=1 with rdata=0 at cycle 16, error=1.
- **Overlap and irq:** SLAVE_PREFIX with slices 1 and 3 both 8'h20, address 0x2000_0004.
  → s_valid=4'b0010.
  → s_irq=4'b1000 gives m_irq=1 independent of FSM state.
- **Reset mid-transaction:** reset low during ACTIVE.
  → s_valid, m_ready and error go to 0 immediately.
  → after release, a fresh read at 0x0000_0000 completes normally.
